fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard controller for the 5-stage RV32I pipeline.
- Keeps its own shadow copy of register-address and control info for the EX, MEM and WB stages.
- Drives the 2-bit selects of the two EX-stage operand 3:1 muxes, and detects load-use hazards.
- Issues a one-cycle stall plus ID/EX bubble on a load-use hazard. Sits beside the ID/EX pipeline register, clocked with the core.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/fwd_stage_reg.sv | 32 +++
 rtl/fwd_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, register-address width
// and the shadow stage-info records carried alongside the core's pipeline registers.
package cpu_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              use1;
      logic              use2;
      logic [REG_AW-1:0] rd;
      logic              wr;
      logic              ld;
   } ex_info_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              wr;
      logic              ld;
   } mem_info_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              wr;
   } wb_info_t;

   // MEM wins over WB; x0 and unused/invalid operands always read the register file.
   function automatic logic [1:0] fwd_sel(input logic              ex_valid,
                                          input logic              use_rs,
                                          input logic [REG_AW-1:0] rs,
                                          input mem_info_t         mem,
                                          input wb_info_t          wb);
      logic [1:0] sel;
      sel = FWD_RF;
      if (ex_valid && use_rs && rs != '0) begin
         if (mem.valid && mem.wr && mem.rd == rs)
            sel = FWD_MEM;
         else if (wb.valid && wb.wr && wb.rd == rs)
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One shadow pipeline stage: holds on hold_i, loads all-zero (invalid) on bubble_i,
// otherwise captures d_i. Asynchronous active-low reset clears it to invalid.
module fwd_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         hold_i,
   input  logic         bubble_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q;
   logic [W-1:0] stage_d;

   always_comb begin
      stage_d = stage_q;
      if (!hold_i)
         stage_d = bubble_i ? '0 : d_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stage_q <= '0;
      else
         stage_q <= stage_d;
   end

   assign q_o = stage_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for the 5-stage RV32I pipeline.
// Define FWD_HAZARD_STALL_CNT_EN to add the saturating stall counter output stall_cnt_o.
module fwd_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int REG_AW = cpu_pkg::REG_AW
`ifdef FWD_HAZARD_STALL_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_reg_write_i,
   input  logic              id_mem_read_i,
   input  logic              hold_i,
   input  logic              flush_i,
   output logic [1:0]        fwd_a_sel_o,
   output logic [1:0]        fwd_b_sel_o,
   output logic              stall_o,
`ifdef FWD_HAZARD_STALL_CNT_EN
   output logic [CNT_W-1:0]  stall_cnt_o,
`endif
   output logic              bubble_o
);

   ex_info_t  ex_d,  ex_q;
   mem_info_t mem_d, mem_q;
   wb_info_t  wb_d,  wb_q;
   logic      load_use;

   always_comb begin
      ex_d.valid = id_valid_i;
      ex_d.rs1   = id_rs1_i;
      ex_d.rs2   = id_rs2_i;
      ex_d.use1  = id_use_rs1_i;
      ex_d.use2  = id_use_rs2_i;
      ex_d.rd    = id_rd_i;
      ex_d.wr    = id_reg_write_i;
      ex_d.ld    = id_mem_read_i;

      mem_d.valid = ex_q.valid;
      mem_d.rd    = ex_q.rd;
      mem_d.wr    = ex_q.wr;
      mem_d.ld    = ex_q.ld;

      wb_d.valid = mem_q.valid;
      wb_d.rd    = mem_q.rd;
      wb_d.wr    = mem_q.wr;
   end

   // A load in EX whose result the ID instruction needs cannot be forwarded in time.
   always_comb begin
      load_use = ex_q.valid && ex_q.ld && ex_q.wr && (ex_q.rd != '0) && id_valid_i &&
                 ((id_use_rs1_i && id_rs1_i == ex_q.rd) ||
                  (id_use_rs2_i && id_rs2_i == ex_q.rd)) &&
                 !flush_i && !hold_i;
   end

   fwd_stage_reg #(.W($bits(ex_info_t))) u_ex_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold_i   (hold_i),
      .bubble_i (flush_i | load_use),
      .d_i      (ex_d),
      .q_o      (ex_q)
   );

   fwd_stage_reg #(.W($bits(mem_info_t))) u_mem_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold_i   (hold_i),
      .bubble_i (1'b0),
      .d_i      (mem_d),
      .q_o      (mem_q)
   );

   fwd_stage_reg #(.W($bits(wb_info_t))) u_wb_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold_i   (hold_i),
      .bubble_i (1'b0),
      .d_i      (wb_d),
      .q_o      (wb_q)
   );

   assign fwd_a_sel_o = fwd_sel(ex_q.valid, ex_q.use1, ex_q.rs1, mem_q, wb_q);
   assign fwd_b_sel_o = fwd_sel(ex_q.valid, ex_q.use2, ex_q.rs2, mem_q, wb_q);
   assign stall_o     = load_use;
   assign bubble_o    = !hold_i && (flush_i || load_use);

`ifdef FWD_HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (load_use && stall_cnt_q != {CNT_W{1'b1}})
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus randomized traffic checked
// against an instruction-history reference model.
module tb_fwd_hazard_ctrl;

   typedef struct {
      bit v;
      int rs1;
      int rs2;
      bit u1;
      bit u2;
      int rd;
      bit wr;
      bit ld;
   } ins_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid_i = 1'b0;
   logic [4:0] id_rs1_i = '0;
   logic [4:0] id_rs2_i = '0;
   logic       id_use_rs1_i = 1'b0;
   logic       id_use_rs2_i = 1'b0;
   logic [4:0] id_rd_i = '0;
   logic       id_reg_write_i = 1'b0;
   logic       id_mem_read_i = 1'b0;
   logic       hold_i = 1'b0;
   logic       flush_i = 1'b0;
   logic [1:0] fwd_a_sel_o;
   logic [1:0] fwd_b_sel_o;
   logic       stall_o;
   logic       bubble_o;
`ifdef FWD_HAZARD_STALL_CNT_EN
   logic [15:0] stall_cnt_o;
`endif

   ins_t hist[$];
   ins_t cur;
   bit   cur_flush;
   bit   cur_hold;
   int   model_cnt;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid_i     (id_valid_i),
      .id_rs1_i       (id_rs1_i),
      .id_rs2_i       (id_rs2_i),
      .id_use_rs1_i   (id_use_rs1_i),
      .id_use_rs2_i   (id_use_rs2_i),
      .id_rd_i        (id_rd_i),
      .id_reg_write_i (id_reg_write_i),
      .id_mem_read_i  (id_mem_read_i),
      .hold_i         (hold_i),
      .flush_i        (flush_i),
      .fwd_a_sel_o    (fwd_a_sel_o),
      .fwd_b_sel_o    (fwd_b_sel_o),
      .stall_o        (stall_o),
`ifdef FWD_HAZARD_STALL_CNT_EN
      .stall_cnt_o    (stall_cnt_o),
`endif
      .bubble_o       (bubble_o)
   );

   function automatic ins_t nop();
      ins_t i;
      i = '{v: 1'b0, rs1: 0, rs2: 0, u1: 1'b0, u2: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
      return i;
   endfunction

   function automatic ins_t alu(int rd, int rs1, int rs2);
      ins_t i;
      i = '{v: 1'b1, rs1: rs1, rs2: rs2, u1: 1'b1, u2: 1'b1, rd: rd, wr: 1'b1, ld: 1'b0};
      return i;
   endfunction

   function automatic ins_t lw(int rd, int rs1);
      ins_t i;
      i = '{v: 1'b1, rs1: rs1, rs2: 0, u1: 1'b1, u2: 1'b0, rd: rd, wr: 1'b1, ld: 1'b1};
      return i;
   endfunction

   // hist[0] is the instruction in EX, hist[1] the one issued before it, hist[2] the one before that.
   function automatic int m_sel(int rs, bit u);
      if (!hist[0].v || !u || rs == 0) return 0;
      if (hist[1].v && hist[1].wr && hist[1].rd == rs) return 2;
      if (hist[2].v && hist[2].wr && hist[2].rd == rs) return 1;
      return 0;
   endfunction

   function automatic bit m_hazard();
      ins_t e;
      e = hist[0];
      return e.v && e.ld && e.wr && e.rd != 0 && cur.v &&
             ((cur.u1 && cur.rs1 == e.rd) || (cur.u2 && cur.rs2 == e.rd)) &&
             !cur_flush && !cur_hold;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < 3; k++) hist.push_back(nop());
      model_cnt = 0;
   endtask

   task automatic drive(ins_t i, bit fl, bit hd);
      cur            = i;
      cur_flush      = fl;
      cur_hold       = hd;
      id_valid_i     = i.v;
      id_rs1_i       = i.rs1[4:0];
      id_rs2_i       = i.rs2[4:0];
      id_use_rs1_i   = i.u1;
      id_use_rs2_i   = i.u2;
      id_rd_i        = i.rd[4:0];
      id_reg_write_i = i.wr;
      id_mem_read_i  = i.ld;
      flush_i        = fl;
      hold_i         = hd;
   endtask

   task automatic tick();
      ins_t nw;
      bit   haz;
      @(posedge clk);
      if (rst_n && !cur_hold) begin
         haz = m_hazard();
         nw  = (cur_flush || haz) ? nop() : cur;
         hist.push_front(nw);
         void'(hist.pop_back());
         if (haz && model_cnt != 65535) model_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic flush_pipe();
      drive(nop(), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick();
   endtask

   task automatic test_reset();
      model_reset();
      drive(nop(), 1'b0, 1'b0);
      #1;
      tests++;
      if ({fwd_a_sel_o, fwd_b_sel_o, stall_o, bubble_o} !== 6'b0) begin
         fails++;
         $display("FAIL reset_initial: got %b expected 000000", {fwd_a_sel_o, fwd_b_sel_o, stall_o, bubble_o});
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(alu(3, 1, 2), 1'b0, 1'b0); tick();
      drive(lw(8, 3), 1'b0, 1'b0);     tick();
      drive(alu(9, 8, 8), 1'b0, 1'b0);
      #1;
      tests++;
      if (fwd_a_sel_o !== 2'b10 || stall_o !== 1'b1) begin
         fails++;
         $display("FAIL reset_prefill: got a=%b stall=%b expected a=10 stall=1", fwd_a_sel_o, stall_o);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({fwd_a_sel_o, fwd_b_sel_o, stall_o, bubble_o} !== 6'b0) begin
         fails++;
         $display("FAIL reset_midop: got %b expected 000000", {fwd_a_sel_o, fwd_b_sel_o, stall_o, bubble_o});
      end
`ifdef FWD_HAZARD_STALL_CNT_EN
      tests++;
      if (stall_cnt_o !== 16'd0) begin
         fails++;
         $display("FAIL reset_cnt: got %0d expected 0", stall_cnt_o);
      end
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(alu(10, 3, 8), 1'b0, 1'b0); tick();
      drive(nop(), 1'b0, 1'b0);
      #1;
      tests++;
      if (fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00) begin
         fails++;
         $display("FAIL reset_first_instr: got a=%b b=%b expected 00 00", fwd_a_sel_o, fwd_b_sel_o);
      end
   endtask

   task automatic test_ex_mem_fwd();
      flush_pipe();
      drive(alu(5, 1, 2), 1'b0, 1'b0); tick();
      drive(alu(6, 5, 7), 1'b0, 1'b0); tick();
      drive(nop(), 1'b0, 1'b0);
      #1;
      tests++;
      if (fwd_a_sel_o !== 2'b10 || fwd_b_sel_o !== 2'b00) begin
         fails++;
         $display("FAIL ex_mem_fwd: got a=%b b=%b expected 10 00", fwd_a_sel_o, fwd_b_sel_o);
      end
   endtask

   task automatic test_priority_x0();
      flush_pipe();
      drive(alu(5, 1, 2), 1'b0, 1'b0);  tick();
      drive(alu(5, 3, 4), 1'b0, 1'b0);  tick();
      drive(alu(10, 5, 5), 1'b0, 1'b0); tick();
      drive(nop(), 1'b0, 1'b0);
      #1;
      tests++;
      if (fwd_a_sel_o !== 2'b10 || fwd_b_sel_o !== 2'b10) begin
         fails++;
         $display("FAIL mem_over_wb: got a=%b b=%b expected 10 10", fwd_a_sel_o, fwd_b_sel_o);
      end
      flush_pipe();
      drive(alu(0, 1, 2), 1'b0, 1'b0);  tick();
      drive(alu(0, 3, 4), 1'b0, 1'b0);  tick();
      drive(alu(11, 0, 0), 1'b0, 1'b0); tick();
      drive(nop(), 1'b0, 1'b0);
      #1;
      tests++;
      if (fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00) begin
         fails++;
         $display("FAIL x0_no_fwd: got a=%b b=%b expected 00 00", fwd_a_sel_o, fwd_b_sel_o);
      end
      flush_pipe();
      drive(alu(5, 1, 2), 1'b0, 1'b0);  tick();
      drive(alu(12, 1, 2), 1'b0, 1'b0); tick();
      drive(alu(13, 5, 6), 1'b0, 1'b0); tick();
      drive(nop(), 1'b0, 1'b0);
      #1;
      tests++;
      if (fwd_a_sel_o !== 2'b01 || fwd_b_sel_o !== 2'b00) begin
         fails++;
         $display("FAIL wb_fwd_gap: got a=%b b=%b expected 01 00", fwd_a_sel_o, fwd_b_sel_o);
      end
   endtask

   task automatic test_load_use();
      flush_pipe();
      drive(lw(8, 1), 1'b0, 1'b0); tick();
      drive(alu(9, 8, 8), 1'b0, 1'b0);
      #1;
      tests++;
      if (stall_o !== 1'b1 || bubble_o !== 1'b1) begin
         fails++;
         $display("FAIL load_use_stall: got stall=%b bubble=%b expected 1 1", stall_o, bubble_o);
      end
      tick();
      drive(alu(9, 8, 8), 1'b0, 1'b0);
      #1;
      tests++;
      if (stall_o !== 1'b0 || bubble_o !== 1'b0 || fwd_a_sel_o !== 2'b00) begin
         fails++;
         $display("FAIL load_use_single: got stall=%b bubble=%b a=%b expected 0 0 00", stall_o, bubble_o, fwd_a_sel_o);
      end
      tick();
      drive(nop(), 1'b0, 1'b0);
      #1;
      tests++;
      if (fwd_a_sel_o !== 2'b01 || fwd_b_sel_o !== 2'b01) begin
         fails++;
         $display("FAIL load_use_fwd: got a=%b b=%b expected 01 01", fwd_a_sel_o, fwd_b_sel_o);
      end
`ifdef FWD_HAZARD_STALL_CNT_EN
      tests++;
      if (stall_cnt_o !== 16'd1) begin
         fails++;
         $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt_o);
      end
`endif
   endtask

   task automatic test_flush_vs_hazard();
      flush_pipe();
      drive(lw(8, 1), 1'b0, 1'b0); tick();
      drive(alu(9, 8, 8), 1'b1, 1'b0);
      #1;
      tests++;
      if (stall_o !== 1'b0 || bubble_o !== 1'b1) begin
         fails++;
         $display("FAIL flush_wins: got stall=%b bubble=%b expected 0 1", stall_o, bubble_o);
      end
      tick();
      drive(nop(), 1'b0, 1'b0);
      #1;
      tests++;
      if (fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00) begin
         fails++;
         $display("FAIL flush_killed: got a=%b b=%b expected 00 00", fwd_a_sel_o, fwd_b_sel_o);
      end
   endtask

   task automatic test_hold();
      flush_pipe();
      drive(alu(3, 1, 2), 1'b0, 1'b0); tick();
      drive(lw(8, 3), 1'b0, 1'b0);     tick();
      drive(alu(9, 8, 8), 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         tests++;
         if (fwd_a_sel_o !== 2'b10 || stall_o !== 1'b0 || bubble_o !== 1'b0) begin
            fails++;
            $display("FAIL hold_frozen[%0d]: got a=%b stall=%b bubble=%b expected 10 0 0", k, fwd_a_sel_o, stall_o, bubble_o);
         end
         tick();
      end
      drive(alu(9, 8, 8), 1'b0, 1'b0);
      #1;
      tests++;
      if (stall_o !== 1'b1 || bubble_o !== 1'b1 || fwd_a_sel_o !== 2'b10) begin
         fails++;
         $display("FAIL hold_release: got stall=%b bubble=%b a=%b expected 1 1 10", stall_o, bubble_o, fwd_a_sel_o);
      end
      tick();
   endtask

   task automatic test_random();
      ins_t i;
      bit   fl, hd;
      int   ea, eb;
      bit   es, eb_o;
      for (int n = 0; n < 400; n++) begin
         i.v   = ($urandom_range(0, 99) < 85);
         i.rd  = $urandom_range(0, 3);
         i.rs1 = $urandom_range(0, 3);
         i.rs2 = $urandom_range(0, 3);
         i.u1  = $urandom_range(0, 1);
         i.u2  = $urandom_range(0, 1);
         i.ld  = ($urandom_range(0, 2) == 0);
         i.wr  = i.ld ? 1'b1 : ($urandom_range(0, 3) != 0);
         fl    = ($urandom_range(0, 9) == 0);
         hd    = ($urandom_range(0, 7) == 0);
         drive(i, fl, hd);
         #1;
         ea   = m_sel(hist[0].rs1, hist[0].u1);
         eb   = m_sel(hist[0].rs2, hist[0].u2);
         es   = m_hazard();
         eb_o = !hd && (fl || es);
         tests++;
         if (fwd_a_sel_o !== ea[1:0] || fwd_b_sel_o !== eb[1:0] || stall_o !== es || bubble_o !== eb_o) begin
            fails++;
            $display("FAIL random[%0d]: got a=%b b=%b stall=%b bubble=%b expected a=%0d b=%0d stall=%b bubble=%b",
                     n, fwd_a_sel_o, fwd_b_sel_o, stall_o, bubble_o, ea, eb, es, eb_o);
         end
         tick();
      end
`ifdef FWD_HAZARD_STALL_CNT_EN
      #1;
      tests++;
      if (stall_cnt_o !== model_cnt[15:0]) begin
         fails++;
         $display("FAIL random_cnt: got %0d expected %0d", stall_cnt_o, model_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_ex_mem_fwd();
      test_priority_x0();
      test_load_use();
      test_flush_vs_hazard();
      test_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
